// File: rtl/des_pkg.sv
// Shared DES definitions: FSM encoding, permutation tables, S-boxes and key shift schedule.
// Tables use DES bit numbering (entry value n selects bit n, bit 1 = MSB).
package des_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2
  } des_state_e;

  localparam int IP_TBL [64] = '{
    58, 50, 42, 34, 26, 18, 10,  2, 60, 52, 44, 36, 28, 20, 12,  4,
    62, 54, 46, 38, 30, 22, 14,  6, 64, 56, 48, 40, 32, 24, 16,  8,
    57, 49, 41, 33, 25, 17,  9,  1, 59, 51, 43, 35, 27, 19, 11,  3,
    61, 53, 45, 37, 29, 21, 13,  5, 63, 55, 47, 39, 31, 23, 15,  7};

  localparam int FP_TBL [64] = '{
    40,  8, 48, 16, 56, 24, 64, 32, 39,  7, 47, 15, 55, 23, 63, 31,
    38,  6, 46, 14, 54, 22, 62, 30, 37,  5, 45, 13, 53, 21, 61, 29,
    36,  4, 44, 12, 52, 20, 60, 28, 35,  3, 43, 11, 51, 19, 59, 27,
    34,  2, 42, 10, 50, 18, 58, 26, 33,  1, 41,  9, 49, 17, 57, 25};

  localparam int PC1_TBL [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_TBL [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  localparam int E_TBL [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int P_TBL [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  // Each S-box is 64 nibbles in row-major order, entry 0 in the top nibble.
  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  // Right rotations that walk C||D back from K16 to K1 during decryption.
  localparam logic [1:0] SHIFT_DEC [16] = '{
    2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

  function automatic logic [1:64] des_ip(input logic [1:64] x);
    logic [1:64] y;
    for (int i = 0; i < 64; i++) y[i+1] = x[IP_TBL[i]];
    return y;
  endfunction

  function automatic logic [1:64] des_fp(input logic [1:64] x);
    logic [1:64] y;
    for (int i = 0; i < 64; i++) y[i+1] = x[FP_TBL[i]];
    return y;
  endfunction

  function automatic logic [1:56] des_pc1(input logic [1:64] x);
    logic [1:56] y;
    for (int i = 0; i < 56; i++) y[i+1] = x[PC1_TBL[i]];
    return y;
  endfunction

  function automatic logic [1:48] des_pc2(input logic [1:56] x);
    logic [1:48] y;
    for (int i = 0; i < 48; i++) y[i+1] = x[PC2_TBL[i]];
    return y;
  endfunction

  function automatic logic [1:48] des_e(input logic [1:32] x);
    logic [1:48] y;
    for (int i = 0; i < 48; i++) y[i+1] = x[E_TBL[i]];
    return y;
  endfunction

  function automatic logic [1:32] des_p(input logic [1:32] x);
    logic [1:32] y;
    for (int i = 0; i < 32; i++) y[i+1] = x[P_TBL[i]];
    return y;
  endfunction

  // Row is {b1,b6} and column b2..b5, so the entry index is {b1,b6,b2,b3,b4,b5}.
  function automatic logic [3:0] des_sbox(input int box, input logic [1:6] x);
    logic [5:0]   idx;
    logic [255:0] shifted;
    idx     = {x[1], x[6], x[2:5]};
    shifted = SBOX[box] >> {~idx, 2'b00};
    return shifted[3:0];
  endfunction

  function automatic logic [1:28] des_rotr28(input logic [1:28] x, input logic [1:0] n);
    logic [1:28] y;
    case (n)
      2'd1:    y = {x[28], x[1:27]};
      2'd2:    y = {x[27:28], x[1:26]};
      default: y = x;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/des_roundfunction.sv
// One Feistel step with swap: l_out = R, r_out = L xor f(R, K).
module des_roundfunction
  import des_pkg::*;
(
  input  logic [1:32] l_in,
  input  logic [1:32] r_in,
  input  logic [1:48] k_in,
  output logic [1:32] l_out,
  output logic [1:32] r_out
);

  logic [1:48] mixed;
  logic [1:32] s_out;

  assign mixed = des_e(r_in) ^ k_in;

  always_comb begin
    s_out = '0;
    for (int b = 0; b < 8; b++) s_out[4*b+1 +: 4] = des_sbox(b, mixed[6*b+1 +: 6]);
  end

  assign l_out = r_in;
  assign r_out = l_in ^ des_p(s_out);

endmodule

// File: rtl/des_decrypt_core.sv
// Iterative DES decryption: one round per clock, fixed 18-cycle block period.
// Subkeys are regenerated on the fly by rotating C||D right, giving K16..K1.
module des_decrypt_core
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:64] ct_in,
  input  logic [1:64] key_in,
  output logic        busy,
  output logic        done,
  output logic [1:64] pt_out
);

  des_state_e  state_q, state_d;
  logic [1:32] l_q, l_d, r_q, r_d;
  logic [1:28] c_q, c_d, d_q, d_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:64] pt_q, pt_d;
  logic        done_q, done_d;

  logic [1:64] ip_ct;
  logic [1:56] pc1_key;
  logic [1:28] c_rot, d_rot;
  logic [1:48] round_key;
  logic [1:32] l_nxt, r_nxt;

  assign ip_ct     = des_ip(ct_in);
  assign pc1_key   = des_pc1(key_in);
  assign c_rot     = des_rotr28(c_q, SHIFT_DEC[cnt_q]);
  assign d_rot     = des_rotr28(d_q, SHIFT_DEC[cnt_q]);
  assign round_key = des_pc2({c_rot, d_rot});

  des_roundfunction u_round (
    .l_in  (l_q),
    .r_in  (r_q),
    .k_in  (round_key),
    .l_out (l_nxt),
    .r_out (r_nxt)
  );

  always_comb begin
    // NOTE: every _d takes its _q value first, so no branch can leave a latch behind.
    state_d = state_q;
    l_d     = l_q;
    r_d     = r_q;
    c_d     = c_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    pt_d    = pt_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          l_d     = ip_ct[1:32];
          r_d     = ip_ct[33:64];
          c_d     = pc1_key[1:28];
          d_d     = pc1_key[29:56];
          cnt_d   = 4'd0;
          state_d = ST_ROUND;
        end
      end
      ST_ROUND: begin
        c_d   = c_rot;
        d_d   = d_rot;
        l_d   = l_nxt;
        r_d   = r_nxt;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = ST_FINAL;
      end
      ST_FINAL: begin
        // Undo the last swap: the output block is R16||L16.
        pt_d    = des_fp({r_q, l_q});
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      l_q     <= '0;
      r_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      pt_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      l_q     <= l_d;
      r_q     <= r_d;
      c_q     <= c_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      pt_q    <= pt_d;
      done_q  <= done_d;
    end
  end

  assign busy   = (state_q != ST_IDLE);
  assign done   = done_q;
  assign pt_out = pt_q;

endmodule

// File: tb/tb_des_decrypt_core.sv
// Scoreboard bench for des_decrypt_core: a driver predicts acceptance and results,
// a monitor compares busy/done/pt_out every cycle against those predictions.
module tb_des_decrypt_core;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [63:0] ct_in;
  logic [63:0] key_in;
  logic        busy;
  logic        done;
  logic [63:0] pt_out;

  des_decrypt_core dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .ct_in  (ct_in),
    .key_in (key_in),
    .busy   (busy),
    .done   (done),
    .pt_out (pt_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference DES (textbook encrypt-order key schedule) ----------------
  int ip_t[$]  = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4, 62,54,46,38,30,22,14,6,
                   64,56,48,40,32,24,16,8, 57,49,41,33,25,17,9,1, 59,51,43,35,27,19,11,3,
                   61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  int fp_t[$]  = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31, 38,6,46,14,54,22,62,30,
                   37,5,45,13,53,21,61,29, 36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                   34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  int pc1_t[$] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                   19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                   14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  int pc2_t[$] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                   41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  int e_t[$]   = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                   16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  int p_t[$]   = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                   2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  int lsh_t[$] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  logic [255:0] sbox_t [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  // Table entry n picks bit n counted from the MSB of an in_w-bit right-aligned value.
  function automatic logic [63:0] permute(input logic [63:0] x, input int in_w, input int tbl[$]);
    logic [63:0] r;
    r = '0;
    foreach (tbl[j]) r = {r[62:0], x[in_w - tbl[j]]};
    return r;
  endfunction

  function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
    logic [63:0]  tmp;
    logic [47:0]  x;
    logic [5:0]   six;
    logic [31:0]  s;
    logic [255:0] box;
    int           idx;
    tmp = permute({32'h0, r}, 32, e_t);
    x   = tmp[47:0] ^ k;
    s   = '0;
    for (int b = 0; b < 8; b++) begin
      six = x[47 - 6*b -: 6];
      idx = 16 * int'({six[5], six[0]}) + int'(six[4:1]);
      box = sbox_t[b];
      s   = {s[27:0], box[255 - 4*idx -: 4]};
    end
    tmp = permute({32'h0, s}, 32, p_t);
    return tmp[31:0];
  endfunction

  function automatic logic [63:0] des_ref(input logic [63:0] key, input logic [63:0] ct);
    logic [63:0] tmp;
    logic [27:0] c, d;
    logic [47:0] sub [16];
    logic [31:0] l, r, t;
    tmp = permute(key, 64, pc1_t);
    c   = tmp[55:28];
    d   = tmp[27:0];
    for (int i = 0; i < 16; i++) begin
      c      = (c << lsh_t[i]) | (c >> (28 - lsh_t[i]));
      d      = (d << lsh_t[i]) | (d >> (28 - lsh_t[i]));
      tmp    = permute({8'h0, c, d}, 56, pc2_t);
      sub[i] = tmp[47:0];
    end
    tmp = permute(ct, 64, ip_t);
    l   = tmp[63:32];
    r   = tmp[31:0];
    for (int i = 15; i >= 0; i--) begin
      t = r;
      r = l ^ feistel(r, sub[i]);
      l = t;
    end
    return permute({r, l}, 64, fp_t);
  endfunction

  // ---------------- scoreboard state ----------------
  typedef struct {
    logic [63:0] pt;
    int          done_edge;
  } sb_entry_t;

  sb_entry_t   sb[$];
  int          edge_no  = 0;
  int          last_acc = -1000;
  logic [63:0] exp_pt   = '0;
  int          n_checks = 0;
  int          n_fail   = 0;

  always @(posedge clk) edge_no <= edge_no + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s @edge %0d: actual=%h required=%h", name, edge_no, act, req);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // A start is taken only if the previous block left IDLE at least 18 edges ago.
  task automatic drive(input logic st, input logic [63:0] ct, input logic [63:0] key,
                       input logic [63:0] req_pt, output bit accepted);
    sb_entry_t ent;
    @(negedge clk);
    start    = st;
    ct_in    = ct;
    key_in   = key;
    accepted = 1'b0;
    if (st && rst_n && (edge_no + 1 - last_acc >= 18)) begin
      accepted      = 1'b1;
      last_acc      = edge_no + 1;
      ent.pt        = req_pt;
      ent.done_edge = edge_no + 18;
      sb.push_back(ent);
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) drive(1'b0, rnd64(), rnd64(), 64'h0, acc);
  endtask

  // ---------------- monitor ----------------
  initial begin
    sb_entry_t ent;
    bit        due;
    bit        busy_exp;
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        check("reset_busy", {63'h0, busy}, 64'h0);
        check("reset_done", {63'h0, done}, 64'h0);
        check("reset_pt_out", pt_out, 64'h0);
      end else begin
        busy_exp = (edge_no - last_acc >= 0) && (edge_no - last_acc <= 16);
        due      = (sb.size() > 0) && (sb[0].done_edge == edge_no);
        check("busy", {63'h0, busy}, {63'h0, busy_exp});
        check("done", {63'h0, done}, {63'h0, due});
        if (due) begin
          ent    = sb.pop_front();
          check("pt_out", pt_out, ent.pt);
          exp_pt = ent.pt;
        end else begin
          check("pt_hold", pt_out, exp_pt);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  localparam logic [63:0] KAT_KEY [2] = '{64'h133457799BBCDFF1, 64'h0000000000000000};
  localparam logic [63:0] KAT_CT  [2] = '{64'h85E813540F0AB405, 64'h8CA64DE9C1B123A7};
  localparam logic [63:0] KAT_PT  [2] = '{64'h0123456789ABCDEF, 64'h0000000000000000};

  initial begin
    bit          acc;
    int          n_acc;
    logic [63:0] ct, key;
    rst_n  = 1'b0;
    start  = 1'b0;
    ct_in  = '0;
    key_in = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Known-answer vectors, one isolated block each.
    for (int v = 0; v < 2; v++) begin
      drive(1'b1, KAT_CT[v], KAT_KEY[v], KAT_PT[v], acc);
      idle(22);
    end

    // Back-to-back with start held high, alternating the two vectors.
    n_acc = 0;
    while (n_acc < 6) begin
      drive(1'b1, KAT_CT[n_acc % 2], KAT_KEY[n_acc % 2], KAT_PT[n_acc % 2], acc);
      if (acc) n_acc++;
    end
    idle(22);

    // Start with other data at edge +5 of an active block is ignored.
    drive(1'b1, KAT_CT[0], KAT_KEY[0], KAT_PT[0], acc);
    idle(4);
    drive(1'b1, rnd64(), rnd64(), 64'h0, acc);
    idle(22);

    // Reset at edge +9 aborts the block; the first start afterwards is taken.
    drive(1'b1, KAT_CT[1], KAT_KEY[1], KAT_PT[1], acc);
    idle(8);
    @(negedge clk);
    rst_n    = 1'b0;
    sb.delete();
    last_acc = -1000;
    exp_pt   = '0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    drive(1'b1, KAT_CT[0], KAT_KEY[0], KAT_PT[0], acc);
    idle(22);

    // Random blocks with random start gaps; inputs keep changing every cycle.
    n_acc = 0;
    while (n_acc < 1000) begin
      ct  = rnd64();
      key = rnd64();
      drive(($urandom_range(0, 3) != 0), ct, key, des_ref(key, ct), acc);
      if (acc) n_acc++;
    end

    for (int i = 0; i < 40 && sb.size() > 0; i++) idle(1);
    idle(2);
    check("scoreboard_drained", 64'(sb.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
